tawas_ls_unit: RTL and testbench

Load/store execution stage for the Tawas two-slice core. It sits between the instruction decoder and the register file. It takes one load/store operation at a time and reads the pointer and store data from the register file. It then runs a single request/ready transaction on the data bus and writes back load data and the updated pointer. Each writeback goes to the register bank of the slice that issued the operation.

---
 rtl/tawas_ls_unit.sv | 249 ++++++++++++++++++++++++
 tb/tb_tawas_ls_unit.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tawas_ls_unit.sv
// tawas_ls_unit: load/store execution stage for the Tawas two-slice core.
// Takes one load/store operation at a time. It computes the effective
// address from the pointer register, runs a single request/ready bus
// transaction, and writes load data and the updated pointer back to the
// register bank of the slice that issued the operation.
// Optional feature macro: TAWAS_LS_MISALIGN_CHK_EN enables misaligned-access
// exceptions. Without it, misaligned addresses are silently aligned down.
module tawas_ls_unit (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        SLICE,
    input  logic        LS_OP_VLD,
    input  logic        LS_OP_STORE,
    input  logic [1:0]  LS_OP_SIZE,
    input  logic        LS_OP_SIGNED,
    input  logic [7:0]  LS_OP_OFFSET,
    input  logic        LS_OP_PTR_UPD,
    input  logic [2:0]  LS_OP_PTR_SEL,
    input  logic [2:0]  LS_OP_DATA_SEL,
    output logic [2:0]  LS_PTR_SEL,
    output logic [2:0]  LS_STORE_SEL,
    input  logic [31:0] LS_PTR,
    input  logic [31:0] LS_STORE,
    output logic        LS_PTR_UPD_VLD,
    output logic [2:0]  LS_PTR_UPD_SEL,
    output logic [31:0] LS_PTR_UPD,
    output logic        LS_LOAD_VLD,
    output logic [2:0]  LS_LOAD_SEL,
    output logic [31:0] LS_LOAD,
    output logic        EC_STORE,
    output logic [31:0] EC,
    output logic        LS_BUSY,
    output logic        D_CS,
    output logic        D_WE,
    output logic [31:0] D_ADDR,
    output logic [3:0]  D_MASK,
    output logic [31:0] D_WR_DATA,
    input  logic        D_RDY,
    input  logic [31:0] D_RD_DATA
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUS  = 2'd1,
        ST_WB   = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic        tag_q, tag_d;
    logic [31:0] ea_q, ea_d;
    logic [31:0] st_data_q, st_data_d;
    logic [1:0]  size_q, size_d;
    logic        signed_q, signed_d;
    logic        store_q, store_d;
    logic        ptr_upd_q, ptr_upd_d;
    logic [2:0]  ptr_sel_q, ptr_sel_d;
    logic [2:0]  data_sel_q, data_sel_d;
    logic [31:0] load_q, load_d;
    logic        busy_q, busy_d;
    logic        d_cs_q, d_cs_d;
    logic        d_we_q, d_we_d;
    logic [3:0]  d_mask_q, d_mask_d;
`ifdef TAWAS_LS_MISALIGN_CHK_EN
    logic        exc_q, exc_d;
    logic        misalign;
`endif

    logic [31:0] off_ext;
    logic [31:0] off_scaled;
    logic [31:0] ea_raw;
    logic [31:0] ea_align;
    logic [31:0] rd_shifted;
    logic [31:0] rd_extended;
    logic        wb_fire;

    // Effective address for the operation offered by the decoder: the signed
    // offset is scaled by access size, and a size-aligned copy is prepared.
    always_comb begin
        off_ext = {{24{LS_OP_OFFSET[7]}}, LS_OP_OFFSET};
        case (LS_OP_SIZE)
            2'b00:   off_scaled = off_ext;
            2'b01:   off_scaled = off_ext << 1;
            default: off_scaled = off_ext << 2;
        endcase
        ea_raw = LS_PTR + off_scaled;
        case (LS_OP_SIZE)
            2'b00:   ea_align = ea_raw;
            2'b01:   ea_align = {ea_raw[31:1], 1'b0};
            default: ea_align = {ea_raw[31:2], 2'b00};
        endcase
`ifdef TAWAS_LS_MISALIGN_CHK_EN
        misalign = ((LS_OP_SIZE == 2'b01) && ea_raw[0]) ||
                   (LS_OP_SIZE[1] && (ea_raw[1:0] != 2'b00));
`endif
    end

    // Read data lane extraction: shift the addressed byte/half down to bit 0,
    // then zero- or sign-extend it according to the captured access size.
    always_comb begin
        rd_shifted = D_RD_DATA >> {ea_q[1:0], 3'b000};
        case (size_q)
            2'b00:   rd_extended = {{24{signed_q & rd_shifted[7]}}, rd_shifted[7:0]};
            2'b01:   rd_extended = {{16{signed_q & rd_shifted[15]}}, rd_shifted[15:0]};
            default: rd_extended = rd_shifted;
        endcase
    end

    // Next-state logic for the IDLE -> BUS -> WB sequence, plus the
    // registered bus outputs derived from the state being entered.
    always_comb begin
        state_d    = state_q;
        tag_d      = tag_q;
        ea_d       = ea_q;
        st_data_d  = st_data_q;
        size_d     = size_q;
        signed_d   = signed_q;
        store_d    = store_q;
        ptr_upd_d  = ptr_upd_q;
        ptr_sel_d  = ptr_sel_q;
        data_sel_d = data_sel_q;
        load_d     = load_q;
`ifdef TAWAS_LS_MISALIGN_CHK_EN
        exc_d      = exc_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (LS_OP_VLD) begin
                    tag_d      = SLICE;
                    st_data_d  = LS_STORE;
                    size_d     = LS_OP_SIZE;
                    signed_d   = LS_OP_SIGNED;
                    store_d    = LS_OP_STORE;
                    ptr_upd_d  = LS_OP_PTR_UPD;
                    ptr_sel_d  = LS_OP_PTR_SEL;
                    data_sel_d = LS_OP_DATA_SEL;
`ifdef TAWAS_LS_MISALIGN_CHK_EN
                    ea_d       = ea_raw;
                    exc_d      = misalign;
                    state_d    = misalign ? ST_WB : ST_BUS;
`else
                    ea_d       = ea_align;
                    state_d    = ST_BUS;
`endif
                end
            end
            ST_BUS: begin
                if (D_RDY) begin
                    load_d  = rd_extended;
                    state_d = (store_q && !ptr_upd_q) ? ST_IDLE : ST_WB;
                end
            end
            ST_WB: begin
                if (SLICE == tag_q) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        busy_d = (state_d != ST_IDLE);
        d_cs_d = (state_d == ST_BUS);
        d_we_d = d_cs_d && store_d;
        if (!d_cs_d) begin
            d_mask_d = 4'b0000;
        end else begin
            case (size_d)
                2'b00:   d_mask_d = 4'b0001 << ea_d[1:0];
                2'b01:   d_mask_d = ea_d[1] ? 4'b1100 : 4'b0011;
                default: d_mask_d = 4'b1111;
            endcase
        end
    end

    // Single state register for the whole unit; synchronous active-low reset.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q    <= ST_IDLE;
            tag_q      <= 1'b0;
            ea_q       <= 32'd0;
            st_data_q  <= 32'd0;
            size_q     <= 2'b00;
            signed_q   <= 1'b0;
            store_q    <= 1'b0;
            ptr_upd_q  <= 1'b0;
            ptr_sel_q  <= 3'd0;
            data_sel_q <= 3'd0;
            load_q     <= 32'd0;
            busy_q     <= 1'b0;
            d_cs_q     <= 1'b0;
            d_we_q     <= 1'b0;
            d_mask_q   <= 4'b0000;
`ifdef TAWAS_LS_MISALIGN_CHK_EN
            exc_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            tag_q      <= tag_d;
            ea_q       <= ea_d;
            st_data_q  <= st_data_d;
            size_q     <= size_d;
            signed_q   <= signed_d;
            store_q    <= store_d;
            ptr_upd_q  <= ptr_upd_d;
            ptr_sel_q  <= ptr_sel_d;
            data_sel_q <= data_sel_d;
            load_q     <= load_d;
            busy_q     <= busy_d;
            d_cs_q     <= d_cs_d;
            d_we_q     <= d_we_d;
            d_mask_q   <= d_mask_d;
`ifdef TAWAS_LS_MISALIGN_CHK_EN
            exc_q      <= exc_d;
`endif
        end
    end

    // Output mapping: writebacks fire only while the issuing slice is current.
    always_comb begin
        wb_fire        = (state_q == ST_WB) && (SLICE == tag_q);
        LS_PTR_SEL     = LS_OP_PTR_SEL;
        LS_STORE_SEL   = LS_OP_DATA_SEL;
        LS_PTR_UPD_SEL = ptr_sel_q;
        LS_PTR_UPD     = ea_q;
        LS_LOAD_SEL    = data_sel_q;
        LS_LOAD        = load_q;
        LS_BUSY        = busy_q;
        D_CS           = d_cs_q;
        D_WE           = d_we_q;
        D_MASK         = d_mask_q;
        D_ADDR         = {ea_q[31:2], 2'b00};
        case (size_q)
            2'b00:   D_WR_DATA = {4{st_data_q[7:0]}};
            2'b01:   D_WR_DATA = {2{st_data_q[15:0]}};
            default: D_WR_DATA = st_data_q;
        endcase
`ifdef TAWAS_LS_MISALIGN_CHK_EN
        LS_LOAD_VLD    = wb_fire && !store_q && !exc_q;
        LS_PTR_UPD_VLD = wb_fire && ptr_upd_q && !exc_q;
        EC_STORE       = wb_fire && exc_q;
        EC             = exc_q ? ea_q : 32'd0;
`else
        LS_LOAD_VLD    = wb_fire && !store_q;
        LS_PTR_UPD_VLD = wb_fire && ptr_upd_q;
        EC_STORE       = 1'b0;
        EC             = 32'd0;
`endif
    end

endmodule

// File: tb/tb_tawas_ls_unit.sv
// tb_tawas_ls_unit: directed, table-driven bench for tawas_ls_unit, with
// hand-written sequences for slice hold, reset abort, busy-ignore and
// misaligned access.
module tb_tawas_ls_unit;

    logic        CLK;
    logic        RST_N;
    logic        SLICE;
    logic        LS_OP_VLD;
    logic        LS_OP_STORE;
    logic [1:0]  LS_OP_SIZE;
    logic        LS_OP_SIGNED;
    logic [7:0]  LS_OP_OFFSET;
    logic        LS_OP_PTR_UPD;
    logic [2:0]  LS_OP_PTR_SEL;
    logic [2:0]  LS_OP_DATA_SEL;
    logic [2:0]  LS_PTR_SEL;
    logic [2:0]  LS_STORE_SEL;
    logic [31:0] LS_PTR;
    logic [31:0] LS_STORE;
    logic        LS_PTR_UPD_VLD;
    logic [2:0]  LS_PTR_UPD_SEL;
    logic [31:0] LS_PTR_UPD;
    logic        LS_LOAD_VLD;
    logic [2:0]  LS_LOAD_SEL;
    logic [31:0] LS_LOAD;
    logic        EC_STORE;
    logic [31:0] EC;
    logic        LS_BUSY;
    logic        D_CS;
    logic        D_WE;
    logic [31:0] D_ADDR;
    logic [3:0]  D_MASK;
    logic [31:0] D_WR_DATA;
    logic        D_RDY;
    logic [31:0] D_RD_DATA;

    int checks;
    int failures;

    typedef struct {
        logic        store;
        logic [1:0]  size;
        logic        sgn;
        logic [7:0]  off;
        logic        upd;
        logic [2:0]  psel;
        logic [2:0]  dsel;
        logic        slice;
        logic [31:0] ptr;
        logic [31:0] st;
        logic [31:0] rd;
        int          waits;
        logic [31:0] exp_addr;
        logic [3:0]  exp_mask;
        logic [31:0] exp_wr;
        logic [31:0] exp_load;
        logic [31:0] exp_ptr;
    } vec_t;

    vec_t vecs[11];

    tawas_ls_unit dut (
        .CLK            (CLK),
        .RST_N          (RST_N),
        .SLICE          (SLICE),
        .LS_OP_VLD      (LS_OP_VLD),
        .LS_OP_STORE    (LS_OP_STORE),
        .LS_OP_SIZE     (LS_OP_SIZE),
        .LS_OP_SIGNED   (LS_OP_SIGNED),
        .LS_OP_OFFSET   (LS_OP_OFFSET),
        .LS_OP_PTR_UPD  (LS_OP_PTR_UPD),
        .LS_OP_PTR_SEL  (LS_OP_PTR_SEL),
        .LS_OP_DATA_SEL (LS_OP_DATA_SEL),
        .LS_PTR_SEL     (LS_PTR_SEL),
        .LS_STORE_SEL   (LS_STORE_SEL),
        .LS_PTR         (LS_PTR),
        .LS_STORE       (LS_STORE),
        .LS_PTR_UPD_VLD (LS_PTR_UPD_VLD),
        .LS_PTR_UPD_SEL (LS_PTR_UPD_SEL),
        .LS_PTR_UPD     (LS_PTR_UPD),
        .LS_LOAD_VLD    (LS_LOAD_VLD),
        .LS_LOAD_SEL    (LS_LOAD_SEL),
        .LS_LOAD        (LS_LOAD),
        .EC_STORE       (EC_STORE),
        .EC             (EC),
        .LS_BUSY        (LS_BUSY),
        .D_CS           (D_CS),
        .D_WE           (D_WE),
        .D_ADDR         (D_ADDR),
        .D_MASK         (D_MASK),
        .D_WR_DATA      (D_WR_DATA),
        .D_RDY          (D_RDY),
        .D_RD_DATA      (D_RD_DATA)
    );

    // Free-running core clock, 10 time units per cycle.
    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // Hard time limit so a stuck run still ends with a visible failure.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic driveOp(input logic store, input logic [1:0] size, input logic sgn,
                           input logic [7:0] off, input logic upd, input logic [2:0] psel,
                           input logic [2:0] dsel, input logic [31:0] ptr, input logic [31:0] st);
        LS_OP_VLD      = 1'b1;
        LS_OP_STORE    = store;
        LS_OP_SIZE     = size;
        LS_OP_SIGNED   = sgn;
        LS_OP_OFFSET   = off;
        LS_OP_PTR_UPD  = upd;
        LS_OP_PTR_SEL  = psel;
        LS_OP_DATA_SEL = dsel;
        LS_PTR         = ptr;
        LS_STORE       = st;
    endtask

    task automatic clearOp();
        LS_OP_VLD = 1'b0;
        LS_PTR    = 32'd0;
        LS_STORE  = 32'd0;
    endtask

    // One complete operation from a table record: accept, bus phase with the
    // requested wait states, then writeback checks and return to idle.
    task automatic applyStimulus(input vec_t v, input int idx);
        string p;
        p = $sformatf("v%0d", idx);
        SLICE = v.slice;
        D_RDY = 1'b0;
        driveOp(v.store, v.size, v.sgn, v.off, v.upd, v.psel, v.dsel, v.ptr, v.st);
        #1;
        checkOutput({p, "_idle_busy"}, {31'd0, LS_BUSY}, 32'd0);
        checkOutput({p, "_ptr_sel"}, {29'd0, LS_PTR_SEL}, {29'd0, v.psel});
        checkOutput({p, "_store_sel"}, {29'd0, LS_STORE_SEL}, {29'd0, v.dsel});
        tick();
        clearOp();
        #1;
        checkOutput({p, "_cs"}, {31'd0, D_CS}, 32'd1);
        checkOutput({p, "_busy"}, {31'd0, LS_BUSY}, 32'd1);
        checkOutput({p, "_addr"}, D_ADDR, v.exp_addr);
        checkOutput({p, "_mask"}, {28'd0, D_MASK}, {28'd0, v.exp_mask});
        checkOutput({p, "_we"}, {31'd0, D_WE}, {31'd0, v.store});
        if (v.store) begin
            checkOutput({p, "_wr_data"}, D_WR_DATA, v.exp_wr);
        end
        for (int w = 0; w < v.waits; w++) begin
            tick();
            checkOutput({p, "_cs_wait"}, {31'd0, D_CS}, 32'd1);
            checkOutput({p, "_addr_wait"}, D_ADDR, v.exp_addr);
        end
        D_RDY     = 1'b1;
        D_RD_DATA = v.rd;
        tick();
        D_RDY     = 1'b0;
        D_RD_DATA = 32'd0;
        #1;
        checkOutput({p, "_cs_done"}, {31'd0, D_CS}, 32'd0);
        if (v.store && !v.upd) begin
            checkOutput({p, "_free"}, {29'd0, LS_BUSY, LS_LOAD_VLD, LS_PTR_UPD_VLD}, 32'd0);
        end else begin
            checkOutput({p, "_load_vld"}, {31'd0, LS_LOAD_VLD}, {31'd0, !v.store});
            checkOutput({p, "_ptr_vld"}, {31'd0, LS_PTR_UPD_VLD}, {31'd0, v.upd});
            if (!v.store) begin
                checkOutput({p, "_load"}, LS_LOAD, v.exp_load);
                checkOutput({p, "_load_sel"}, {29'd0, LS_LOAD_SEL}, {29'd0, v.dsel});
            end
            if (v.upd) begin
                checkOutput({p, "_ptr_upd"}, LS_PTR_UPD, v.exp_ptr);
                checkOutput({p, "_ptr_upd_sel"}, {29'd0, LS_PTR_UPD_SEL}, {29'd0, v.psel});
            end
            tick();
            checkOutput({p, "_end"}, {29'd0, LS_BUSY, LS_LOAD_VLD, LS_PTR_UPD_VLD}, 32'd0);
        end
        checkOutput({p, "_ec"}, {31'd0, EC_STORE}, 32'd0);
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        RST_N     = 1'b0;
        SLICE     = 1'b0;
        D_RDY     = 1'b0;
        D_RD_DATA = 32'd0;
        driveOp(1'b0, 2'b00, 1'b0, 8'h00, 1'b0, 3'd0, 3'd0, 32'd0, 32'd0);
        clearOp();

        //                store size  sgn off    upd psel dsel slc ptr           st            rd            wt  addr          mask     wr            load          ptr
        vecs[0]  = '{1'b0, 2'b10, 1'b0, 8'h02, 1'b0, 3'd1, 3'd3, 1'b0, 32'h00000100, 32'h0,        32'hCAFEBABE, 2, 32'h00000108, 4'b1111, 32'h0,        32'hCAFEBABE, 32'h0};
        vecs[1]  = '{1'b0, 2'b00, 1'b1, 8'h03, 1'b0, 3'd1, 3'd2, 1'b1, 32'h00000200, 32'h0,        32'h80123456, 1, 32'h00000200, 4'b1000, 32'h0,        32'hFFFFFF80, 32'h0};
        vecs[2]  = '{1'b0, 2'b00, 1'b0, 8'h03, 1'b0, 3'd1, 3'd2, 1'b0, 32'h00000200, 32'h0,        32'h80123456, 0, 32'h00000200, 4'b1000, 32'h0,        32'h00000080, 32'h0};
        vecs[3]  = '{1'b1, 2'b01, 1'b0, 8'hFF, 1'b1, 3'd2, 3'd4, 1'b0, 32'h00001002, 32'h1234ABCD, 32'h0,        0, 32'h00001000, 4'b0011, 32'hABCDABCD, 32'h0,        32'h00001000};
        vecs[4]  = '{1'b1, 2'b00, 1'b0, 8'h01, 1'b0, 3'd3, 3'd5, 1'b1, 32'h00000040, 32'h000000A5, 32'h0,        1, 32'h00000040, 4'b0010, 32'hA5A5A5A5, 32'h0,        32'h0};
        vecs[5]  = '{1'b0, 2'b01, 1'b1, 8'h01, 1'b1, 3'd4, 3'd5, 1'b0, 32'h00000300, 32'h0,        32'h80017FFF, 0, 32'h00000300, 4'b1100, 32'h0,        32'hFFFF8001, 32'h00000302};
        vecs[6]  = '{1'b0, 2'b01, 1'b0, 8'hFE, 1'b0, 3'd5, 3'd6, 1'b1, 32'h00000500, 32'h0,        32'h1234F00D, 3, 32'h000004FC, 4'b0011, 32'h0,        32'h0000F00D, 32'h0};
        vecs[7]  = '{1'b1, 2'b11, 1'b0, 8'h80, 1'b0, 3'd6, 3'd7, 1'b1, 32'h00000800, 32'hDEADBEEF, 32'h0,        0, 32'h00000600, 4'b1111, 32'hDEADBEEF, 32'h0,        32'h0};
        vecs[8]  = '{1'b0, 2'b10, 1'b0, 8'h01, 1'b1, 3'd6, 3'd6, 1'b0, 32'h00000020, 32'h0,        32'h0BADF00D, 0, 32'h00000024, 4'b1111, 32'h0,        32'h0BADF00D, 32'h00000024};
        vecs[9]  = '{1'b0, 2'b00, 1'b1, 8'h00, 1'b0, 3'd0, 3'd1, 1'b1, 32'h00000010, 32'h0,        32'h1234567F, 0, 32'h00000010, 4'b0001, 32'h0,        32'h0000007F, 32'h0};
        vecs[10] = '{1'b1, 2'b00, 1'b0, 8'hF0, 1'b1, 3'd7, 3'd0, 1'b0, 32'h10000003, 32'h000000C3, 32'h0,        0, 32'h0FFFFFF0, 4'b1000, 32'hC3C3C3C3, 32'h0,        32'h0FFFFFF3};

        // Reset state
        tick();
        tick();
        checkOutput("rst_busy", {31'd0, LS_BUSY}, 32'd0);
        checkOutput("rst_bus", {26'd0, D_CS, D_WE, D_MASK}, 32'd0);
        checkOutput("rst_addr", D_ADDR, 32'd0);
        checkOutput("rst_valids", {29'd0, LS_LOAD_VLD, LS_PTR_UPD_VLD, EC_STORE}, 32'd0);
        RST_N = 1'b1;
        tick();

        // Table-driven operations
        for (int i = 0; i < 11; i++) begin
            applyStimulus(vecs[i], i);
        end

        // Slice hold: accept at SLICE=1, D_RDY while SLICE=0, first WB cycle
        // still SLICE=0 so the writeback waits one cycle for SLICE=1.
        SLICE = 1'b1;
        driveOp(1'b0, 2'b10, 1'b0, 8'h00, 1'b0, 3'd1, 3'd2, 32'h00000100, 32'h0);
        tick();
        clearOp();
        SLICE     = 1'b0;
        D_RDY     = 1'b1;
        D_RD_DATA = 32'h12345678;
        #1;
        checkOutput("hold_cs", {31'd0, D_CS}, 32'd1);
        tick();
        D_RDY = 1'b0;
        SLICE = 1'b0;
        #1;
        checkOutput("hold_wait_vld", {30'd0, LS_LOAD_VLD, LS_BUSY}, 32'd1);
        tick();
        SLICE = 1'b1;
        #1;
        checkOutput("hold_vld", {31'd0, LS_LOAD_VLD}, 32'd1);
        checkOutput("hold_load", LS_LOAD, 32'h12345678);
        tick();
        checkOutput("hold_end", {30'd0, LS_BUSY, LS_LOAD_VLD}, 32'd0);

        // Reset during BUS abandons the transaction without writeback; D_RDY
        // arriving afterwards while idle is ignored.
        SLICE = 1'b0;
        driveOp(1'b0, 2'b10, 1'b0, 8'h00, 1'b1, 3'd3, 3'd4, 32'h00000400, 32'h0);
        tick();
        clearOp();
        #1;
        checkOutput("rstbus_cs", {31'd0, D_CS}, 32'd1);
        RST_N = 1'b0;
        tick();
        RST_N = 1'b1;
        #1;
        checkOutput("rstbus_after", {30'd0, D_CS, LS_BUSY}, 32'd0);
        D_RDY     = 1'b1;
        D_RD_DATA = 32'hFFFFFFFF;
        for (int k = 0; k < 2; k++) begin
            tick();
            checkOutput("rstbus_no_wb", {28'd0, LS_LOAD_VLD, LS_PTR_UPD_VLD, D_CS, LS_BUSY}, 32'd0);
        end
        D_RDY     = 1'b0;
        D_RD_DATA = 32'd0;

        // A new operation offered while busy must not disturb the current one
        // nor be accepted afterwards.
        driveOp(1'b0, 2'b10, 1'b0, 8'h00, 1'b0, 3'd1, 3'd2, 32'h00000300, 32'h0);
        tick();
        driveOp(1'b1, 2'b00, 1'b0, 8'h05, 1'b1, 3'd7, 3'd7, 32'h00000999, 32'h77);
        tick();
        checkOutput("ignore_addr", D_ADDR, 32'h00000300);
        checkOutput("ignore_we", {31'd0, D_WE}, 32'd0);
        clearOp();
        D_RDY     = 1'b1;
        D_RD_DATA = 32'h00000011;
        tick();
        D_RDY     = 1'b0;
        #1;
        checkOutput("ignore_load", LS_LOAD, 32'h00000011);
        checkOutput("ignore_vld", {30'd0, LS_LOAD_VLD, LS_PTR_UPD_VLD}, 32'd2);
        tick();
        checkOutput("ignore_idle", {30'd0, LS_BUSY, D_CS}, 32'd0);

        // Misaligned word access at EA=0x102.
        SLICE = 1'b0;
        driveOp(1'b0, 2'b10, 1'b0, 8'h00, 1'b1, 3'd1, 3'd2, 32'h00000102, 32'h0);
        tick();
        clearOp();
        #1;
`ifdef TAWAS_LS_MISALIGN_CHK_EN
        checkOutput("mis_cs", {31'd0, D_CS}, 32'd0);
        checkOutput("mis_ec_store", {31'd0, EC_STORE}, 32'd1);
        checkOutput("mis_ec", EC, 32'h00000102);
        checkOutput("mis_no_wb", {30'd0, LS_LOAD_VLD, LS_PTR_UPD_VLD}, 32'd0);
        tick();
        checkOutput("mis_end", {29'd0, EC_STORE, LS_BUSY, D_CS}, 32'd0);
`else
        checkOutput("mis_cs", {31'd0, D_CS}, 32'd1);
        checkOutput("mis_addr", D_ADDR, 32'h00000100);
        checkOutput("mis_mask", {28'd0, D_MASK}, 32'hF);
        D_RDY     = 1'b1;
        D_RD_DATA = 32'h55667788;
        tick();
        D_RDY     = 1'b0;
        #1;
        checkOutput("mis_load", LS_LOAD, 32'h55667788);
        checkOutput("mis_ptr", LS_PTR_UPD, 32'h00000100);
        checkOutput("mis_ec_store", {31'd0, EC_STORE}, 32'd0);
        tick();
        checkOutput("mis_end", {31'd0, LS_BUSY}, 32'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
